// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Adds two WIDTH-bit operands plus a carry-in, one bit per clock. A single
// full-adder slice (two half_adder instances and an OR gate) is reused for
// every bit position. Jobs are requested with a start pulse. o_busy covers
// the whole job. o_done pulses once when the result is valid.
//
// Ports:
//   i_clk    : clock; all state updates on the rising edge
//   i_rst    : asynchronous active-high reset
//   i_start  : job request, sampled only while idle
//   i_a, i_b : operands, captured when a start is accepted
//   i_cin    : carry-in, captured when a start is accepted
//   o_busy   : high while a job is in progress (ADD or DONE)
//   o_done   : one-cycle pulse, the result is valid
//   o_sum    : result sum, held until the next completion
//   o_carry  : result carry-out, held until the next completion
// -----------------------------------------------------------------------------

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    // The last sum bit comes straight from the adder slice, so the register
    // only has to hold the WIDTH-1 bits that were produced earlier.
    logic [WIDTH-2:0] shift_sum;
    logic [WIDTH-1:0] sum_shifted;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt;

    logic s1, c1, s2, c2;
    logic carry_nxt;
    logic last_bit;

    half_adder u_ha1 (
        .a (shift_a[0]),
        .b (shift_b[0]),
        .s (s1),
        .c (c1)
    );

    half_adder u_ha2 (
        .a (s1),
        .b (carry_reg),
        .s (s2),
        .c (c2)
    );

    assign carry_nxt   = c1 | c2;
    assign last_bit    = (cnt == CNT_LAST);
    // The new bit enters at the MSB. Once all WIDTH bits are done, this
    // value is the complete sum.
    assign sum_shifted = {s2, shift_sum};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = ADD;
            ADD:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_sum     <= '0;
            o_carry   <= 1'b0;
            shift_a   <= '0;
            shift_b   <= '0;
            shift_sum <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
        end else begin
            state  <= state_nxt;
            // The outputs are registered copies of the next state, so they
            // line up with the state register and never glitch.
            o_busy <= (state_nxt != IDLE);
            o_done <= (state_nxt == DONE);

            case (state)
                IDLE: begin
                    if (i_start) begin
                        shift_a   <= i_a;
                        shift_b   <= i_b;
                        carry_reg <= i_cin;
                        shift_sum <= '0;
                        cnt       <= '0;
                    end
                end
                ADD: begin
                    shift_a   <= shift_a >> 1;
                    shift_b   <= shift_b >> 1;
                    shift_sum <= sum_shifted[WIDTH-1:1];
                    carry_reg <= carry_nxt;
                    if (last_bit) begin
                        // The counter holds at its last value and is reloaded
                        // by the next start, so it never wraps.
                        o_sum   <= sum_shifted;
                        o_carry <= carry_nxt;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    logic clk;
    logic rst;

    logic       start, cin, busy, done, carry;
    logic [7:0] a, b, sum;

    logic       start2, cin2, busy2, done2, carry2;
    logic [1:0] a2, b2, sum2;

    logic        start32, cin32, busy32, done32, carry32;
    logic [31:0] a32, b32, sum32;

    int passed = 0;
    int total  = 0;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_a(a), .i_b(b), .i_cin(cin),
        .o_busy(busy), .o_done(done), .o_sum(sum), .o_carry(carry)
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .i_a(a2), .i_b(b2), .i_cin(cin2),
        .o_busy(busy2), .o_done(done2), .o_sum(sum2), .o_carry(carry2)
    );

    serial_adder_ctrl #(.WIDTH(32)) dut32 (
        .i_clk(clk), .i_rst(rst), .i_start(start32), .i_a(a32), .i_b(b32), .i_cin(cin32),
        .o_busy(busy32), .o_done(done32), .o_sum(sum32), .o_carry(carry32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        a   = 8'($urandom);
        b   = 8'($urandom);
        cin = 1'($urandom);
    endtask

    // Returns the number of edges until o_done is seen, or -1 on timeout.
    task automatic wait_done8(output int cyc);
        cyc = -1;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int cyc;
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b0;
        tick();
        start = 1'b0; scramble();
        wait_done8(cyc);
        total++; if (cyc !== 8) $display("FAIL reset_prejob_lat: got %0d want 8", cyc); else passed++;
        total++; if ({carry, sum} !== 9'h1FE) $display("FAIL reset_prejob_val: got %h want 1fe", {carry, sum}); else passed++;
        tick();
        #3 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL reset_async_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_async_done: got %b want 0", done); else passed++;
        total++; if (sum !== 8'h00) $display("FAIL reset_async_sum: got %h want 00", sum); else passed++;
        total++; if (carry !== 1'b0) $display("FAIL reset_async_carry: got %b want 0", carry); else passed++;
        #2 rst = 1'b0;
        tick();
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done); else passed++;
    endtask

    task automatic test_basic();
        start = 1'b1; a = 8'h35; b = 8'h4A; cin = 1'b0;
        tick();
        start = 1'b0; scramble();
        total++; if (busy !== 1'b1) $display("FAIL basic_busy c0: got %b want 1", busy); else passed++;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++; if (busy !== 1'b1) $display("FAIL basic_busy c%0d: got %b want 1", i, busy); else passed++;
            total++; if (done !== (i == 8)) $display("FAIL basic_done c%0d: got %b want %b", i, done, (i == 8)); else passed++;
            if (i < 8) begin
                total++; if (sum !== 8'h00) $display("FAIL basic_sum_early c%0d: got %h want 00", i, sum); else passed++;
            end
        end
        total++; if (sum !== 8'h7F || carry !== 1'b0) $display("FAIL basic_result: got %b/%h want 0/7f", carry, sum); else passed++;
        tick();
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL basic_end: got busy=%b done=%b want 0 0", busy, done); else passed++;
        total++; if (sum !== 8'h7F) $display("FAIL basic_hold: got %h want 7f", sum); else passed++;
    endtask

    task automatic test_back_to_back();
        int cyc;
        start = 1'b1; a = 8'hFF; b = 8'h01; cin = 1'b0;
        tick();
        a = 8'hFF; b = 8'hFF; cin = 1'b1;
        wait_done8(cyc);
        total++; if (cyc !== 8) $display("FAIL b2b_lat1: got %0d want 8", cyc); else passed++;
        total++; if ({carry, sum} !== 9'h100) $display("FAIL b2b_val1: got %h want 100", {carry, sum}); else passed++;
        tick();
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_idle: got busy=%b done=%b want 0 0", busy, done); else passed++;
        tick();
        total++; if (busy !== 1'b1) $display("FAIL b2b_accept2: got %b want 1", busy); else passed++;
        start = 1'b0; scramble();
        wait_done8(cyc);
        total++; if (cyc !== 8) $display("FAIL b2b_lat2: got %0d want 8", cyc); else passed++;
        total++; if ({carry, sum} !== 9'h1FF) $display("FAIL b2b_val2: got %h want 1ff", {carry, sum}); else passed++;
        tick();
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_end: got busy=%b done=%b want 0 0", busy, done); else passed++;
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        logic [8:0] got = '0;
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        tick();
        for (int i = 1; i <= 12; i++) begin
            start = (i == 3) || (i == 9);
            a = 8'hAA; b = 8'h55; cin = 1'b0;
            tick();
            if (done) begin
                ndone++;
                got = {carry, sum};
            end
        end
        start = 1'b0;
        total++; if (ndone !== 1) $display("FAIL ignore_ndone: got %0d want 1", ndone); else passed++;
        total++; if (got !== 9'h030) $display("FAIL ignore_val: got %h want 030", got); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL ignore_no_second_job: got busy=%b want 0", busy); else passed++;
        total++; if ({carry, sum} !== 9'h030) $display("FAIL ignore_hold: got %h want 030", {carry, sum}); else passed++;
    endtask

    task automatic test_reset_midjob();
        int cyc;
        int ndone = 0;
        start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
        tick();
        start = 1'b0; scramble();
        repeat (3) tick();
        #3 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midrst_ctrl: got busy=%b done=%b want 0 0", busy, done); else passed++;
        total++; if ({carry, sum} !== 9'h000) $display("FAIL midrst_out: got %h want 000", {carry, sum}); else passed++;
        #2 rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) ndone++;
        end
        total++; if (ndone !== 0) $display("FAIL midrst_no_done: got %0d want 0", ndone); else passed++;
        total++; if ({carry, sum} !== 9'h000) $display("FAIL midrst_after: got %h want 000", {carry, sum}); else passed++;
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b1;
        tick();
        start = 1'b0; scramble();
        wait_done8(cyc);
        total++; if (cyc !== 8) $display("FAIL midrst_lat: got %0d want 8", cyc); else passed++;
        total++; if ({carry, sum} !== 9'h047) $display("FAIL midrst_val: got %h want 047", {carry, sum}); else passed++;
        tick();
    endtask

    task automatic test_random8();
        int cyc;
        int spurious = 0;
        logic [7:0] ea, eb;
        logic       ec;
        logic [8:0] exp_v;
        for (int j = 0; j < 200; j++) begin
            repeat ($urandom_range(0, 5)) begin
                tick();
                if (done) spurious++;
            end
            ea = 8'($urandom); eb = 8'($urandom); ec = 1'($urandom);
            exp_v = {1'b0, ea} + {1'b0, eb} + {8'd0, ec};
            start = 1'b1; a = ea; b = eb; cin = ec;
            tick();
            start = 1'b0; scramble();
            total++; if (busy !== 1'b1) $display("FAIL rnd8_accept j%0d: got %b want 1", j, busy); else passed++;
            wait_done8(cyc);
            total++; if (cyc !== 8) $display("FAIL rnd8_lat j%0d: got %0d want 8", j, cyc); else passed++;
            total++; if ({carry, sum} !== exp_v) $display("FAIL rnd8_val j%0d: %h+%h+%b got %h want %h", j, ea, eb, ec, {carry, sum}, exp_v); else passed++;
            tick();
            total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL rnd8_end j%0d: got busy=%b done=%b want 0 0", j, busy, done); else passed++;
        end
        total++; if (spurious !== 0) $display("FAIL rnd8_spurious: got %0d want 0", spurious); else passed++;
    endtask

    task automatic test_width2();
        int cyc;
        logic [1:0] ea, eb;
        logic       ec;
        logic [2:0] exp_v;
        for (int j = 0; j < 60; j++) begin
            repeat ($urandom_range(0, 3)) tick();
            ea = 2'($urandom); eb = 2'($urandom); ec = 1'($urandom);
            exp_v = {1'b0, ea} + {1'b0, eb} + {2'd0, ec};
            start2 = 1'b1; a2 = ea; b2 = eb; cin2 = ec;
            tick();
            start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
            cyc = -1;
            for (int i = 1; i <= 40; i++) begin
                tick();
                if (done2) begin
                    cyc = i;
                    break;
                end
            end
            total++; if (cyc !== 2) $display("FAIL w2_lat j%0d: got %0d want 2", j, cyc); else passed++;
            total++; if ({carry2, sum2} !== exp_v) $display("FAIL w2_val j%0d: got %h want %h", j, {carry2, sum2}, exp_v); else passed++;
            tick();
            total++; if (done2 !== 1'b0 || busy2 !== 1'b0) $display("FAIL w2_end j%0d: got busy=%b done=%b want 0 0", j, busy2, done2); else passed++;
        end
    endtask

    task automatic test_width32();
        int cyc;
        logic [31:0] ea, eb;
        logic        ec;
        logic [32:0] exp_v;
        for (int j = 0; j < 60; j++) begin
            repeat ($urandom_range(0, 3)) tick();
            ea = $urandom; eb = $urandom; ec = 1'($urandom);
            if (j == 0) begin
                ea = 32'hFFFF_FFFF; eb = 32'hFFFF_FFFF; ec = 1'b1;
            end
            exp_v = {1'b0, ea} + {1'b0, eb} + {32'd0, ec};
            start32 = 1'b1; a32 = ea; b32 = eb; cin32 = ec;
            tick();
            start32 = 1'b0; a32 = $urandom; b32 = $urandom; cin32 = 1'($urandom);
            cyc = -1;
            for (int i = 1; i <= 80; i++) begin
                tick();
                if (done32) begin
                    cyc = i;
                    break;
                end
            end
            total++; if (cyc !== 32) $display("FAIL w32_lat j%0d: got %0d want 32", j, cyc); else passed++;
            total++; if ({carry32, sum32} !== exp_v) $display("FAIL w32_val j%0d: got %h want %h", j, {carry32, sum32}, exp_v); else passed++;
            tick();
            total++; if (done32 !== 1'b0 || busy32 !== 1'b0) $display("FAIL w32_end j%0d: got busy=%b done=%b want 0 0", j, busy32, done32); else passed++;
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        start32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;
        #22 rst = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_start();
        test_reset_midjob();
        test_random8();
        test_width2();
        test_width32();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller that time-shares one full-adder slice, built from two half_adder instances plus an OR gate, to add two WIDTH-bit operands over WIDTH clock cycles.
- Sequences operand shifting, carry propagation and result capture through a start/busy/done handshake.
- Sits between a requester issuing add jobs and the shared half_adder datapath, trading latency for area.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst  input  1  asynchronous active-high reset
i_start  input  1  job request; sampled only in IDLE
i_a  input  WIDTH  operand A; captured on accepted start
i_b  input  WIDTH  operand B; captured on accepted start
i_cin  input  1  carry-in; captured on accepted start
o_busy  output  1  high while a job is in progress (ADD or DONE)
o_done  output  1  single-cycle pulse; result valid
o_sum  output  WIDTH  result sum; held until next completion
o_carry  output  1  result carry-out; held until next completion

Behaviour:
- Reset (async, i_rst=1):
  - state=IDLE; o_busy=0, o_done=0, o_sum=0, o_carry=0.
  - Internal shift registers, carry register and bit counter all cleared.
  - Takes effect immediately, independent of i_clk.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - o_busy=0.
  - On an edge with i_start=1: load shift_a=i_a, shift_b=i_b, carry_reg=i_cin, cnt=0; go to ADD.
  - i_start=0: stay in IDLE.
- ADD (o_busy=1), each edge:
  - HA1 adds shift_a[0], shift_b[0] -> s1, c1.
  - HA2 adds s1 and carry_reg -> s2, c2.
  - sum bit = s2; carry_reg <= c1|c2.
  - shift_a and shift_b shift right by 1.
  - shift_sum shifts right with s2 inserted at the MSB.
  - cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1 (WIDTH-th bit processed): o_sum <= final shift_sum including this bit, o_carry <= c1|c2, go to DONE.
- DONE:
  - o_busy=1, o_done=1 for exactly one cycle.
  - Next edge: go to IDLE unconditionally.
- Latency: start accepted at edge E0 -> o_done high in the cycle following edge E0+WIDTH. Throughput is one job per WIDTH+2 cycles.
- o_sum/o_carry change only on the ADD->DONE edge. No partial results are ever visible; values hold through IDLE and the next job until its completion.
- i_start while busy (ADD or DONE) is ignored, not queued. Operands and cin may change freely after acceptance.
- i_start held high continuously: a new job is accepted on the first IDLE edge after DONE.
- Arithmetic: {o_carry,o_sum} == i_a + i_b + i_cin, computed modulo 2^(WIDTH+1). Overflow is reported only via o_carry.
- cnt is sized to clog2(WIDTH) bits. It never reaches WIDTH and does not wrap.
- Reset mid-job: the job is discarded, no o_done pulse, outputs return to 0. The next accepted start behaves as from power-up.
- No X propagation: all registers have reset values; outputs are driven registers only.

Test Plan:
- Reset: assert i_rst asynchronously between clock edges -> o_busy, o_done, o_sum, o_carry read 0 immediately; FSM in IDLE after release.
- WIDTH=8, i_a=0x35, i_b=0x4A, i_cin=0, 1-cycle start -> o_busy high for 9 cycles; o_done pulses 8 cycles after the start edge with o_sum=0x7F, o_carry=0. Check o_sum does not change before that edge.
- Carry chain, checked as two back-to-back jobs:
  - 0xFF+0x01, cin=0 -> o_sum=0x00, o_carry=1.
  - 0xFF+0xFF, cin=1 -> o_sum=0xFF, o_carry=1.
  - Second job accepted on the first IDLE edge with i_start held high.
- Start 0x10+0x20; pulse i_start with i_a=0xAA, i_b=0x55 on cycles 3 and 9 -> single o_done with o_sum=0x30, o_carry=0; no second job started.
- Start 0x80+0x80, assert i_rst at cycle 4 -> no o_done, outputs 0. Then 0x12+0x34, cin=1 -> o_sum=0x47, o_carry=0.
- 200 random jobs with random i_cin and random inter-job gaps (0..5 cycles), plus WIDTH=2 and WIDTH=32 builds -> every o_done matches the reference i_a+i_b+i_cin. Exactly one o_done per accepted start.
